pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard, forwarding and pipeline-control unit for the five-stage IF/ID/EX/MEM/WB processor. It replaces the purely combinational hazard unit. New capabilities: configurable register-file size, multi-cycle load-use stalls via a counter FSM, a memory-busy freeze, per-boundary stall/flush outputs, and saturating stall/flush performance counters. It sits beside the pipeline registers and drives their enable and flush inputs, plus the EX-stage operand forwarding muxes.

## Interface
Parameters:
- NREG, 16: architectural register count; RA_W = $clog2(NREG) is the register-address width.
- LOAD_LAT, 1: load-use bubble cycles, ≥1.
- HAS_ZERO_REG, 0: 1 means register 0 is hardwired; it never forwards and never causes a stall.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- id_valid, id_ra_used, id_rb_used  in  1 each  decode-stage instruction valid and operand-use flags.
- id_ra, id_rb  in  RA_W each  decode-stage source registers.
- ex_valid, ex_reg_write, ex_is_load, ex_branch_taken  in  1 each  EX-stage instruction status.
- ex_ra, ex_rb, ex_rd  in  RA_W each  EX-stage source and destination registers.
- mem_valid, mem_reg_write, mem_is_load  in  1 each  MEM-stage status.
- mem_rd  in  RA_W  MEM-stage destination register.
- wb_valid, wb_reg_write  in  1 each  WB-stage status.
- wb_rd  in  RA_W  WB-stage destination register.
- mem_busy  in  1  data memory not ready; the pipeline must freeze.
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM registers.
- flush_id, flush_ex, flush_mem, flush_wb  out  1 each  clear IF-ID / ID-EX / EX-MEM / MEM-WB registers to a bubble.
- forward_a, forward_b  out  2 each  EX operand select: 00 regfile, 01 EX/MEM aluResult, 10 MEM/WB Result.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.
- ld_stall_active  out  1  FSM is in LD_STALL.

## Operation
Register matching:
- match(x, rd) = (x == rd), gated with (rd != 0) when HAS_ZERO_REG = 1.

Forwarding (combinational, per operand, shown for A):
- forward_a = 01 when mem_valid & mem_reg_write & !mem_is_load & match(ex_ra, mem_rd).
- Otherwise forward_a = 10 when wb_valid & wb_reg_write & match(ex_ra, wb_rd).
- Otherwise forward_a = 00. EX/MEM has priority over MEM/WB.
- forward_b uses the same rule on ex_rb.

Load-use detect:
- lu = id_valid & ex_valid & ex_is_load & ex_reg_write & ((id_ra_used & match(id_ra, ex_rd)) | (id_rb_used & match(id_rb, ex_rd))).

FSM states: RUN and LD_STALL, with down-counter lcnt of width $clog2(LOAD_LAT+1). Priority order per cycle:
1. mem_busy
2. branch = ex_valid & ex_branch_taken
3. load-use

Per-cycle behaviour:
- mem_busy: stall_if, stall_id, stall_ex and stall_mem all 1; flush_wb = 1; every other flush 0. FSM state and lcnt hold. Branch and lu are ignored this cycle.
- branch, not busy: flush_id = flush_ex = 1, stalls 0. FSM goes to RUN and lcnt clears, aborting any load stall.
- RUN with lu: stall_if = stall_id = 1, flush_ex = 1 (bubble into EX).
  - LOAD_LAT = 1: stay in RUN.
  - LOAD_LAT > 1: go to LD_STALL with lcnt = LOAD_LAT−1.
- LD_STALL: stall_if = stall_id = 1, flush_ex = 1. lcnt decrements; when lcnt == 1 (the last bubble), next state is RUN.
- Otherwise all stall and flush outputs are 0.

Counters:
- stall_cnt increments on any cycle with stall_if = 1.
- flush_cnt increments on any cycle with flush_id = 1 (branch flush).
- Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the current state, so they are valid in the same cycle as their cause.
- FSM, lcnt and counters update on the rising clk edge.
- Load-use penalty is exactly LOAD_LAT cycles of stall_id; each mem_busy cycle adds one more.
- Reset (rst = 0, asynchronous, any time including mid-stall):
  - state = RUN, lcnt = 0, stall_cnt = flush_cnt = 0, ld_stall_active = 0.
  - All stall and flush outputs read 0 while reset is held.
  - forward_a and forward_b follow the inputs.
- No new load-use detection is taken while in LD_STALL; the EX stage then holds a bubble.

## Test plan
- Reset mid-LD_STALL (LOAD_LAT = 3, drop rst on the 2nd stall cycle) -> outputs 0 immediately, counters 0, state RUN; normal operation resumes after rst = 1.
- ex_ra = 3, mem_rd = 3 and wb_rd = 3, both writing -> forward_a = 01. Then set mem_valid = 0 -> 10. Then set mem_is_load = 1 with mem_valid = 1 -> 10.
- LOAD_LAT = 2, EX load to r5, ID reads r5 -> stall_if/stall_id/flush_ex high for exactly 2 cycles, stall_cnt = 2, ld_stall_active high in cycle 2 only.
- LOAD_LAT = 3, branch taken in EX during stall cycle 2 -> flush_id = flush_ex = 1 that cycle, next cycle stalls 0, flush_cnt = 1.
- LOAD_LAT = 2 with mem_busy for 3 cycles starting at stall cycle 1 -> freeze with flush_wb = 1; stall_id high for 5 cycles total.
- HAS_ZERO_REG = 1, load to r0 with ID reading r0 -> no stall, forward = 00. Separately, CNT_W = 4 with 20 stall cycles -> stall_cnt = 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl
// ----------------------------------------------------------------------------
// Hazard, forwarding and pipeline-control unit for the five-stage
// IF/ID/EX/MEM/WB processor. It drives the enable (stall) and flush inputs of
// the pipeline registers and the EX-stage operand forwarding muxes.
//
// Parameters
//   NREG         architectural register count (RA_W = $clog2(NREG))
//   LOAD_LAT     number of load-use bubble cycles (>= 1)
//   HAS_ZERO_REG 1: register 0 is hardwired, never forwards or stalls
//   CNT_W        width of the saturating performance counters
//
// Ports
//   clk                         pipeline clock
//   rst                         asynchronous, active-low reset
//   id_valid/id_ra_used/id_rb_used, id_ra/id_rb
//                               decode-stage instruction and source operands
//   ex_valid/ex_reg_write/ex_is_load/ex_branch_taken, ex_ra/ex_rb/ex_rd
//                               EX-stage instruction status and registers
//   mem_valid/mem_reg_write/mem_is_load, mem_rd
//                               MEM-stage status and destination
//   wb_valid/wb_reg_write, wb_rd
//                               WB-stage status and destination
//   mem_busy                    data memory not ready: freeze the pipeline
//   stall_if/id/ex/mem          hold PC / IF-ID / ID-EX / EX-MEM registers
//   flush_id/ex/mem/wb          bubble IF-ID / ID-EX / EX-MEM / MEM-WB
//   forward_a/forward_b         00 regfile, 01 EX/MEM ALU, 10 MEM/WB result
//   stall_cnt/flush_cnt         saturating stall / branch-flush counters
//   ld_stall_active             FSM is in the multi-cycle load stall state
// ============================================================================
module pipe_hazard_ctrl #(
    parameter  int NREG         = 16,
    parameter  int LOAD_LAT     = 1,
    parameter  int HAS_ZERO_REG = 0,
    parameter  int CNT_W        = 16,
    localparam int RA_W         = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             id_valid,
    input  logic             id_ra_used,
    input  logic             id_rb_used,
    input  logic [RA_W-1:0]  id_ra,
    input  logic [RA_W-1:0]  id_rb,

    input  logic             ex_valid,
    input  logic             ex_reg_write,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic [RA_W-1:0]  ex_ra,
    input  logic [RA_W-1:0]  ex_rb,
    input  logic [RA_W-1:0]  ex_rd,

    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic             mem_is_load,
    input  logic [RA_W-1:0]  mem_rd,

    input  logic             wb_valid,
    input  logic             wb_reg_write,
    input  logic [RA_W-1:0]  wb_rd,

    input  logic             mem_busy,

    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_mem,
    output logic             flush_wb,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             ld_stall_active
);

    localparam int LW = $clog2(LOAD_LAT + 1);

    typedef enum logic [0:0] {
        S_RUN      = 1'b0,
        S_LD_STALL = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    // Register compare; a hardwired r0 never matches anything.
    function automatic logic reg_match(input logic [RA_W-1:0] x,
                                       input logic [RA_W-1:0] rd);
        logic m;
        m = (x == rd);
        if (HAS_ZERO_REG != 0) begin
            m = m && (rd != '0);
        end
        return m;
    endfunction

    // Forward select for one EX operand. A load in MEM has no ALU result
    // worth forwarding, so it falls through to the MEM/WB check.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_valid && mem_reg_write && !mem_is_load && reg_match(src, mem_rd)) begin
            sel = 2'b01;
        end else if (wb_valid && wb_reg_write && reg_match(src, wb_rd)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = v;
        if (v != {CNT_W{1'b1}}) begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Registers and combinational nets
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [LW-1:0]    r_lcnt;
    logic [LW-1:0]    w_lcnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_branch;
    logic             w_lu;

    logic             w_stall_if;
    logic             w_stall_id;
    logic             w_stall_ex;
    logic             w_stall_mem;
    logic             w_flush_id;
    logic             w_flush_ex;
    logic             w_flush_mem;
    logic             w_flush_wb;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_branch = ex_valid & ex_branch_taken;

    assign w_lu = id_valid & ex_valid & ex_is_load & ex_reg_write &
                  ((id_ra_used & reg_match(id_ra, ex_rd)) |
                   (id_rb_used & reg_match(id_rb, ex_rd)));

    // Forwarding is purely combinational and is not gated by reset.
    assign forward_a = fwd_sel(ex_ra);
    assign forward_b = fwd_sel(ex_rb);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lcnt  <= w_lcnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (mem_busy > branch > load-use)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_lcnt_nxt  = r_lcnt;
        if (mem_busy) begin
            // Frozen: state and bubble count hold.
            w_state_nxt = r_state;
            w_lcnt_nxt  = r_lcnt;
        end else if (w_branch) begin
            // A taken branch squashes the stalled instruction anyway.
            w_state_nxt = S_RUN;
            w_lcnt_nxt  = '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // With LOAD_LAT == 1 the single bubble is produced in RUN.
                    if (w_lu && (LOAD_LAT > 1)) begin
                        w_state_nxt = S_LD_STALL;
                        w_lcnt_nxt  = LW'(LOAD_LAT - 1);
                    end
                end
                S_LD_STALL: begin
                    w_lcnt_nxt = r_lcnt - {{(LW-1){1'b0}}, 1'b1};
                    if (r_lcnt <= {{(LW-1){1'b0}}, 1'b1}) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                    w_lcnt_nxt  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_stall_if  = 1'b0;
        w_stall_id  = 1'b0;
        w_stall_ex  = 1'b0;
        w_stall_mem = 1'b0;
        w_flush_id  = 1'b0;
        w_flush_ex  = 1'b0;
        w_flush_mem = 1'b0;
        w_flush_wb  = 1'b0;
        if (!rst) begin
            // Everything quiet while reset is asserted.
            w_stall_if = 1'b0;
        end else if (mem_busy) begin
            // Freeze IF..MEM; WB retires so a bubble is written behind it.
            w_stall_if  = 1'b1;
            w_stall_id  = 1'b1;
            w_stall_ex  = 1'b1;
            w_stall_mem = 1'b1;
            w_flush_wb  = 1'b1;
        end else if (w_branch) begin
            w_flush_id = 1'b1;
            w_flush_ex = 1'b1;
        end else if (r_state == S_LD_STALL) begin
            // New load-use detection is ignored here: EX holds a bubble.
            w_stall_if = 1'b1;
            w_stall_id = 1'b1;
            w_flush_ex = 1'b1;
        end else if (w_lu) begin
            w_stall_if = 1'b1;
            w_stall_id = 1'b1;
            w_flush_ex = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_if) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_flush_id) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign stall_if        = w_stall_if;
    assign stall_id        = w_stall_id;
    assign stall_ex        = w_stall_ex;
    assign stall_mem       = w_stall_mem;
    assign flush_id        = w_flush_id;
    assign flush_ex        = w_flush_ex;
    assign flush_mem       = w_flush_mem;
    assign flush_wb        = w_flush_wb;
    assign stall_cnt       = r_stall_cnt;
    assign flush_cnt       = r_flush_cnt;
    assign ld_stall_active = (r_state == S_LD_STALL);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl
// ----------------------------------------------------------------------------
// Three instances share one stimulus stream:
//   inst 0: LOAD_LAT=2, HAS_ZERO_REG=0, CNT_W=16
//   inst 1: LOAD_LAT=3, HAS_ZERO_REG=0, CNT_W=16
//   inst 2: LOAD_LAT=1, HAS_ZERO_REG=1, CNT_W=4
// The driver applies one directed vector per cycle and queues the expected
// output word for the instance(s) of interest; the monitor compares on the
// falling edge. Output word layout:
//   [44:41] stall if,id,ex,mem  [40:37] flush id,ex,mem,wb
//   [36:35] forward_a  [34:33] forward_b  [32] ld_stall_active
//   [31:16] stall_cnt  [15:0] flush_cnt
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int RA_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            id_valid, id_ra_used, id_rb_used;
    logic [RA_W-1:0] id_ra, id_rb;
    logic            ex_valid, ex_reg_write, ex_is_load, ex_branch_taken;
    logic [RA_W-1:0] ex_ra, ex_rb, ex_rd;
    logic            mem_valid, mem_reg_write, mem_is_load;
    logic [RA_W-1:0] mem_rd;
    logic            wb_valid, wb_reg_write;
    logic [RA_W-1:0] wb_rd;
    logic            mem_busy;

    logic [2:0]       sif, sid, sex, smem, fid, fex, fmem, fwb, lda;
    logic [2:0][1:0]  fa, fb;
    logic [1:0][15:0] sc, fc;
    logic [3:0]       zsc, zfc;

    pipe_hazard_ctrl #(.NREG(16), .LOAD_LAT(2), .HAS_ZERO_REG(0), .CNT_W(16)) u_l2 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
        .id_ra(id_ra), .id_rb(id_rb),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken), .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
        .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .mem_busy(mem_busy),
        .stall_if(sif[0]), .stall_id(sid[0]), .stall_ex(sex[0]), .stall_mem(smem[0]),
        .flush_id(fid[0]), .flush_ex(fex[0]), .flush_mem(fmem[0]), .flush_wb(fwb[0]),
        .forward_a(fa[0]), .forward_b(fb[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0]),
        .ld_stall_active(lda[0])
    );

    pipe_hazard_ctrl #(.NREG(16), .LOAD_LAT(3), .HAS_ZERO_REG(0), .CNT_W(16)) u_l3 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
        .id_ra(id_ra), .id_rb(id_rb),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken), .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
        .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .mem_busy(mem_busy),
        .stall_if(sif[1]), .stall_id(sid[1]), .stall_ex(sex[1]), .stall_mem(smem[1]),
        .flush_id(fid[1]), .flush_ex(fex[1]), .flush_mem(fmem[1]), .flush_wb(fwb[1]),
        .forward_a(fa[1]), .forward_b(fb[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1]),
        .ld_stall_active(lda[1])
    );

    pipe_hazard_ctrl #(.NREG(16), .LOAD_LAT(1), .HAS_ZERO_REG(1), .CNT_W(4)) u_z (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ra_used(id_ra_used), .id_rb_used(id_rb_used),
        .id_ra(id_ra), .id_rb(id_rb),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken), .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
        .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .mem_busy(mem_busy),
        .stall_if(sif[2]), .stall_id(sid[2]), .stall_ex(sex[2]), .stall_mem(smem[2]),
        .flush_id(fid[2]), .flush_ex(fex[2]), .flush_mem(fmem[2]), .flush_wb(fwb[2]),
        .forward_a(fa[2]), .forward_b(fb[2]), .stall_cnt(zsc), .flush_cnt(zfc),
        .ld_stall_active(lda[2])
    );

    logic [44:0] obs [3];
    assign obs[0] = {sif[0], sid[0], sex[0], smem[0], fid[0], fex[0], fmem[0], fwb[0],
                     fa[0], fb[0], lda[0], sc[0], fc[0]};
    assign obs[1] = {sif[1], sid[1], sex[1], smem[1], fid[1], fex[1], fmem[1], fwb[1],
                     fa[1], fb[1], lda[1], sc[1], fc[1]};
    assign obs[2] = {sif[2], sid[2], sex[2], smem[2], fid[2], fex[2], fmem[2], fwb[2],
                     fa[2], fb[2], lda[2], 12'd0, zsc, 12'd0, zfc};

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          cyc;
        int          vec;
        int          inst;
        logic [44:0] mask;
        logic [44:0] exp;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   vec_id   = 0;
    int   n_vec    = 0;
    int   n_fail   = 0;
    bit   drv_done = 1'b0;
    int   drain    = 0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [44:0] ov(input logic [3:0] st, input logic [3:0] fl,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic ld, input int s, input int f);
        logic [15:0] s16, f16;
        s16 = s[15:0];
        f16 = f[15:0];
        return {st, fl, a, b, ld, s16, f16};
    endfunction

    logic [44:0] M_ALL, M_NOCNT, M_FWD;

    task automatic expect_v(input int inst, input logic [44:0] m, input logic [44:0] e);
        exp_t x;
        x.cyc  = cyc;
        x.vec  = vec_id;
        x.inst = inst;
        x.mask = m;
        x.exp  = e;
        vec_id++;
        q.push_back(x);
    endtask

    // Monitor: compares every queued expectation due this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            n_vec++;
            if (mon_e.cyc != cyc || ((obs[mon_e.inst] ^ mon_e.exp) & mon_e.mask) != '0) begin
                n_fail++;
                $display("FAIL vec%0d inst%0d cyc%0d: got=%h want=%h mask=%h",
                         mon_e.vec, mon_e.inst, cyc, obs[mon_e.inst] & mon_e.mask,
                         mon_e.exp & mon_e.mask, mon_e.mask);
            end
        end
        if (drv_done) begin
            drain++;
            if (q.size() == 0 || drain > 20) begin
                if (q.size() != 0) begin
                    $display("FAIL drain: %0d expectations never checked", q.size());
                    n_fail += q.size();
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
                $finish;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_ra_used = 0; id_rb_used = 0; id_ra = 0; id_rb = 0;
        ex_valid = 0; ex_reg_write = 0; ex_is_load = 0; ex_branch_taken = 0;
        ex_ra = 0; ex_rb = 0; ex_rd = 0;
        mem_valid = 0; mem_reg_write = 0; mem_is_load = 0; mem_rd = 0;
        wb_valid = 0; wb_reg_write = 0; wb_rd = 0;
        mem_busy = 0;
    endtask

    // Load to r5 in EX, decode instruction reading r5 on operand A.
    task automatic set_lu();
        ex_valid = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd = 4'd5;
        id_valid = 1; id_ra_used = 1; id_ra = 4'd5;
    endtask

    task automatic rst_pulse();
        step(); rst = 0; idle();
        step(); rst = 1;
    endtask

    localparam logic [3:0] ST_LU = 4'b1100, FL_LU = 4'b0100;
    localparam logic [3:0] ST_BZ = 4'b1111, FL_BZ = 4'b0001;
    localparam logic [3:0] FL_BR = 4'b1100;

    initial begin
        M_ALL   = '1;
        M_NOCNT = ov(4'hf, 4'hf, 2'b11, 2'b11, 1'b1, 0, 0);
        M_FWD   = ov(4'h0, 4'h0, 2'b11, 2'b11, 1'b0, 0, 0);
        idle();
        rst = 0;

        // Reset state on all instances
        step();
        for (int i = 0; i < 3; i++) expect_v(i, M_ALL, ov(0, 0, 0, 0, 0, 0, 0));
        step(); rst = 1;

        // Forwarding priority
        step(); idle();
        ex_ra = 3; mem_valid = 1; mem_reg_write = 1; mem_rd = 3;
        wb_valid = 1; wb_reg_write = 1; wb_rd = 3;
        expect_v(0, M_NOCNT, ov(0, 0, 2'b01, 2'b00, 0, 0, 0));
        expect_v(2, M_FWD,   ov(0, 0, 2'b01, 2'b00, 0, 0, 0));
        step(); mem_valid = 0;
        expect_v(0, M_NOCNT, ov(0, 0, 2'b10, 2'b00, 0, 0, 0));
        step(); mem_valid = 1; mem_is_load = 1;
        expect_v(0, M_NOCNT, ov(0, 0, 2'b10, 2'b00, 0, 0, 0));
        step(); mem_is_load = 0; ex_rb = 4; wb_rd = 4;
        expect_v(0, M_NOCNT, ov(0, 0, 2'b01, 2'b10, 0, 0, 0));
        step(); wb_reg_write = 0;
        expect_v(0, M_NOCNT, ov(0, 0, 2'b01, 2'b00, 0, 0, 0));

        // LOAD_LAT = 2 load-use (and LOAD_LAT = 1 single bubble)
        rst_pulse();
        step(); idle(); set_lu();
        expect_v(0, M_ALL, ov(ST_LU, FL_LU, 0, 0, 0, 0, 0));
        expect_v(2, M_ALL, ov(ST_LU, FL_LU, 0, 0, 0, 0, 0));
        step(); ex_valid = 0;
        expect_v(0, M_ALL, ov(ST_LU, FL_LU, 0, 0, 1, 1, 0));
        expect_v(2, M_ALL, ov(0, 0, 0, 0, 0, 1, 0));
        step(); idle();
        expect_v(0, M_ALL, ov(0, 0, 0, 0, 0, 2, 0));

        // LOAD_LAT = 3, branch taken on stall cycle 2
        rst_pulse();
        step(); idle(); set_lu();
        expect_v(1, M_ALL, ov(ST_LU, FL_LU, 0, 0, 0, 0, 0));
        step(); ex_is_load = 0; ex_reg_write = 0; ex_branch_taken = 1;
        expect_v(1, M_ALL, ov(0, FL_BR, 0, 0, 1, 1, 0));
        step(); idle();
        expect_v(1, M_ALL, ov(0, 0, 0, 0, 0, 1, 1));

        // LOAD_LAT = 2 with mem_busy for 3 cycles from stall cycle 1
        rst_pulse();
        for (int k = 0; k < 3; k++) begin
            step(); idle(); set_lu(); mem_busy = 1;
            expect_v(0, M_ALL, ov(ST_BZ, FL_BZ, 0, 0, 0, k, 0));
        end
        step(); mem_busy = 0;
        expect_v(0, M_ALL, ov(ST_LU, FL_LU, 0, 0, 0, 3, 0));
        step(); ex_valid = 0;
        expect_v(0, M_ALL, ov(ST_LU, FL_LU, 0, 0, 1, 4, 0));
        step(); idle();
        expect_v(0, M_ALL, ov(0, 0, 0, 0, 0, 5, 0));

        // Hardwired r0
        rst_pulse();
        step(); idle();
        ex_valid = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd = 0;
        id_valid = 1; id_ra_used = 1; id_ra = 0; id_rb_used = 1; id_rb = 0;
        mem_valid = 1; mem_reg_write = 1; mem_rd = 0;
        wb_valid = 1; wb_reg_write = 1; wb_rd = 0;
        expect_v(2, M_ALL, ov(0, 0, 2'b00, 2'b00, 0, 0, 0));
        expect_v(0, M_ALL, ov(ST_LU, FL_LU, 2'b01, 2'b01, 0, 0, 0));
        step(); idle();
        ex_ra = 2; mem_valid = 1; mem_reg_write = 1; mem_rd = 2;
        wb_valid = 1; wb_reg_write = 1; wb_rd = 0;
        expect_v(2, M_NOCNT, ov(0, 0, 2'b01, 2'b00, 0, 0, 0));
        expect_v(0, M_FWD,   ov(0, 0, 2'b01, 2'b10, 0, 0, 0));

        // CNT_W = 4 saturation over 20 stall cycles
        rst_pulse();
        for (int k = 0; k < 20; k++) begin
            step(); idle(); mem_busy = 1;
            expect_v(2, M_ALL, ov(ST_BZ, FL_BZ, 0, 0, 0, (k > 15) ? 15 : k, 0));
        end
        step(); idle();
        expect_v(2, M_ALL, ov(0, 0, 0, 0, 0, 15, 0));

        // Reset asserted on stall cycle 2 of a LOAD_LAT = 3 stall
        rst_pulse();
        step(); idle(); set_lu();
        expect_v(1, M_ALL, ov(ST_LU, FL_LU, 0, 0, 0, 0, 0));
        step(); rst = 0; ex_valid = 0;
        expect_v(1, M_ALL, ov(0, 0, 0, 0, 0, 0, 0));
        step(); set_lu(); ex_ra = 7; mem_valid = 1; mem_reg_write = 1; mem_rd = 7;
        expect_v(1, M_ALL, ov(0, 0, 2'b01, 2'b00, 0, 0, 0));
        step(); rst = 1; idle(); set_lu();
        expect_v(1, M_ALL, ov(ST_LU, FL_LU, 0, 0, 0, 0, 0));
        step(); ex_valid = 0;
        expect_v(1, M_ALL, ov(ST_LU, FL_LU, 0, 0, 1, 1, 0));
        step();
        expect_v(1, M_ALL, ov(ST_LU, FL_LU, 0, 0, 1, 2, 0));
        step(); idle();
        expect_v(1, M_ALL, ov(0, 0, 0, 0, 0, 3, 0));

        step();
        drv_done = 1'b1;
    end

endmodule
